video_timing_sched: RTL and testbench



---
 rtl/video_timing_sched.sv | 174 +++++++++++++++++
 tb/tb_video_timing_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_sched.sv
// Pixel-rate raster scheduler for the TMDS output path (clk_x5 domain).
// Define TIMING_CHECK_EN to reject illegal timing offers with a cfg_err pulse.
module video_timing_sched #(
    parameter int DIV     = 5,
    parameter int CW      = 10,
    parameter int H_TOTAL = 800,
    parameter int H_SYNC  = 96,
    parameter int H_ACT0  = 144,
    parameter int H_ACT1  = 784,
    parameter int V_TOTAL = 525,
    parameter int V_SYNC  = 2,
    parameter int V_ACT0  = 35,
    parameter int V_ACT1  = 515
) (
    input  logic            clk_x5,
    input  logic            resetn,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [8*CW-1:0] cfg_data,
    output logic            cfg_err,
    output logic            pix_stb,
    output logic            de,
    output logic            hsync,
    output logic            vsync,
    output logic [CW-1:0]   x,
    output logic [CW-1:0]   y,
    output logic            frame_end
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);

    localparam int I_HT  = 0;
    localparam int I_HS  = 1;
    localparam int I_HA0 = 2;
    localparam int I_HA1 = 3;
    localparam int I_VT  = 4;
    localparam int I_VS  = 5;
    localparam int I_VA0 = 6;
    localparam int I_VA1 = 7;

    // Field order matches cfg_data: H_TOTAL in the lowest CW bits.
    typedef logic [7:0][CW-1:0] timing_t;
    localparam timing_t DEF_TIMING = {CW'(V_ACT1), CW'(V_ACT0), CW'(V_SYNC), CW'(V_TOTAL),
                                      CW'(H_ACT1), CW'(H_ACT0), CW'(H_SYNC), CW'(H_TOTAL)};

    logic [PW-1:0] r_phase;
    logic          r_pix_stb;
    logic          r_frame_end;
    logic          r_pending;
    logic          r_de;
    logic          r_hsync;
    logic          r_vsync;
    logic [CW-1:0] r_hc;
    logic [CW-1:0] r_vc;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    timing_t       r_act;
    timing_t       r_shadow;

    logic          w_phase_last;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_xfer;
    logic          w_apply;
    logic          w_cfg_ok;
    logic [CW-1:0] w_hc_n;
    logic [CW-1:0] w_vc_n;
    logic          w_de_n;
    logic          w_hs_n;
    logic          w_vs_n;
    timing_t       w_nxt_t;

    // ">=" keeps the counters bounded even if a smaller TOTAL is applied.
    assign w_phase_last = (r_phase == PH_LAST);
    assign w_h_last     = (r_hc >= r_act[I_HT] - CW'(1));
    assign w_v_last     = (r_vc >= r_act[I_VT] - CW'(1));
    assign w_xfer       = cfg_valid & ~r_pending;
    assign w_apply      = r_frame_end & r_pending;
    assign w_nxt_t      = w_apply ? r_shadow : r_act;

    always_comb begin
        w_hc_n = r_hc + CW'(1);
        w_vc_n = r_vc;
        if (w_h_last) begin
            w_hc_n = '0;
            w_vc_n = w_v_last ? '0 : r_vc + CW'(1);
        end
    end

    // Decode the position the counters are about to hold, under the timing that will be active.
    always_comb begin
        w_hs_n = (w_hc_n < w_nxt_t[I_HS]);
        w_vs_n = (w_vc_n < w_nxt_t[I_VS]);
        w_de_n = (w_hc_n >= w_nxt_t[I_HA0]) && (w_hc_n < w_nxt_t[I_HA1]) &&
                 (w_vc_n >= w_nxt_t[I_VA0]) && (w_vc_n < w_nxt_t[I_VA1]);
    end

`ifdef TIMING_CHECK_EN
    timing_t w_cfg;
    logic    r_err;

    assign w_cfg    = cfg_data;
    assign w_cfg_ok = (w_cfg[I_HS] < w_cfg[I_HA0]) && (w_cfg[I_HA0] < w_cfg[I_HA1]) &&
                      (w_cfg[I_HA1] <= w_cfg[I_HT]) &&
                      (w_cfg[I_VS] < w_cfg[I_VA0]) && (w_cfg[I_VA0] < w_cfg[I_VA1]) &&
                      (w_cfg[I_VA1] <= w_cfg[I_VT]) &&
                      (w_cfg[I_HT] >= CW'(2)) && (w_cfg[I_VT] >= CW'(2));

    always_ff @(posedge clk_x5 or negedge resetn) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_xfer & ~w_cfg_ok;
        end
    end

    assign cfg_err = r_err;
`else
    assign w_cfg_ok = 1'b1;
    assign cfg_err  = 1'b0;
`endif

    always_ff @(posedge clk_x5 or negedge resetn) begin
        if (!resetn) begin
            r_phase     <= '0;
            r_pix_stb   <= 1'b0;
            r_frame_end <= 1'b0;
            r_pending   <= 1'b0;
            r_hc        <= '0;
            r_vc        <= '0;
            r_de        <= 1'b0;
            r_hsync     <= 1'b1;
            r_vsync     <= 1'b1;
            r_x         <= '0;
            r_y         <= '0;
            r_act       <= DEF_TIMING;
            r_shadow    <= DEF_TIMING;
        end else begin
            r_phase     <= w_phase_last ? '0 : r_phase + PW'(1);
            r_pix_stb   <= w_phase_last;
            // Counters are stable on this edge because the strobe lives in phase 0.
            r_frame_end <= w_phase_last & w_h_last & w_v_last;

            if (r_pix_stb) begin
                r_hc    <= w_hc_n;
                r_vc    <= w_vc_n;
                r_hsync <= w_hs_n;
                r_vsync <= w_vs_n;
                r_de    <= w_de_n;
                r_x     <= w_de_n ? w_hc_n - w_nxt_t[I_HA0] : '0;
                r_y     <= w_de_n ? w_vc_n - w_nxt_t[I_VA0] : '0;
            end

            // Apply needs pending=1 and transfer needs pending=0, so these never collide.
            if (w_apply) begin
                r_act     <= r_shadow;
                r_pending <= 1'b0;
            end else if (w_xfer && w_cfg_ok) begin
                r_shadow  <= cfg_data;
                r_pending <= 1'b1;
            end
        end
    end

    assign cfg_ready = ~r_pending;
    assign pix_stb   = r_pix_stb;
    assign frame_end = r_frame_end;
    assign de        = r_de;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign x         = r_x;
    assign y         = r_y;

endmodule

// File: tb/tb_video_timing_sched.sv
// Bench for video_timing_sched: linear-pixel reference model, randomized timing offers.
// Compile with TIMING_CHECK_EN defined to exercise config rejection.
module tb_video_timing_sched;
    localparam int DIV   = 5;
    localparam int CW    = 10;
    localparam int P_HT  = 24;
    localparam int P_HS  = 3;
    localparam int P_HA0 = 5;
    localparam int P_HA1 = 21;
    localparam int P_VT  = 12;
    localparam int P_VS  = 2;
    localparam int P_VA0 = 3;
    localparam int P_VA1 = 10;

    logic            clk_x5 = 1'b0;
    logic            resetn = 1'b0;
    logic            cfg_valid = 1'b0;
    logic [8*CW-1:0] cfg_data = '0;
    logic            cfg_ready;
    logic            cfg_err;
    logic            pix_stb;
    logic            de;
    logic            hsync;
    logic            vsync;
    logic [CW-1:0]   x;
    logic [CW-1:0]   y;
    logic            frame_end;

    video_timing_sched #(
        .DIV(DIV), .CW(CW),
        .H_TOTAL(P_HT), .H_SYNC(P_HS), .H_ACT0(P_HA0), .H_ACT1(P_HA1),
        .V_TOTAL(P_VT), .V_SYNC(P_VS), .V_ACT0(P_VA0), .V_ACT1(P_VA1)
    ) dut (
        .clk_x5(clk_x5), .resetn(resetn),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_err(cfg_err),
        .pix_stb(pix_stb), .de(de), .hsync(hsync), .vsync(vsync),
        .x(x), .y(y), .frame_end(frame_end)
    );

    always #5 clk_x5 = ~clk_x5;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: cycles since reset release, pixel index within the frame, timings.
    int m_k;
    int m_fp;
    int m_t[8];
    int m_sh[8];
    bit m_pending;
    bit m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 25)
                $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic logic [8*CW-1:0] pack_cfg(input int ht, input int hs, input int ha0,
                                                 input int ha1, input int vt, input int vs,
                                                 input int va0, input int va1);
        return {CW'(va1), CW'(va0), CW'(vs), CW'(vt), CW'(ha1), CW'(ha0), CW'(hs), CW'(ht)};
    endfunction

    function automatic bit cfg_legal(input logic [8*CW-1:0] d);
        int f[8];
        for (int i = 0; i < 8; i++) f[i] = int'(d[i*CW +: CW]);
        return (f[1] < f[2]) && (f[2] < f[3]) && (f[3] <= f[0]) &&
               (f[5] < f[6]) && (f[6] < f[7]) && (f[7] <= f[4]) &&
               (f[0] >= 2) && (f[4] >= 2);
    endfunction

    function automatic logic [8*CW-1:0] rand_legal_cfg();
        int ht, hs, ha0, ha1, vt, vs, va0, va1;
        ht  = $urandom_range(16, 4);
        hs  = $urandom_range(ht - 3, 1);
        ha0 = $urandom_range(ht - 2, hs + 1);
        ha1 = $urandom_range(ht, ha0 + 1);
        vt  = $urandom_range(10, 3);
        vs  = $urandom_range(vt - 2, 1);
        va0 = $urandom_range(vt - 1, vs + 1);
        va1 = $urandom_range(vt, va0 + 1);
        return pack_cfg(ht, hs, ha0, ha1, vt, vs, va0, va1);
    endfunction

    task automatic model_reset();
        m_k       = 0;
        m_fp      = 0;
        m_t       = '{P_HT, P_HS, P_HA0, P_HA1, P_VT, P_VS, P_VA0, P_VA1};
        m_sh      = m_t;
        m_pending = 1'b0;
        m_err     = 1'b0;
    endtask

    task automatic check_outputs();
        int hc, vc;
        bit e_stb, e_fe, e_de;
        e_stb = (m_k > 0) && (m_k % DIV == 0);
        hc    = m_fp % m_t[0];
        vc    = m_fp / m_t[0];
        e_fe  = e_stb && (m_fp == m_t[0] * m_t[4] - 1);
        e_de  = (hc >= m_t[2]) && (hc < m_t[3]) && (vc >= m_t[6]) && (vc < m_t[7]);
        check_eq("pix_stb", pix_stb, e_stb);
        check_eq("frame_end", frame_end, e_fe);
        check_eq("hsync", hsync, hc < m_t[1]);
        check_eq("vsync", vsync, vc < m_t[5]);
        check_eq("de", de, e_de);
        check_eq("x", x, e_de ? hc - m_t[2] : 0);
        check_eq("y", y, e_de ? vc - m_t[6] : 0);
        check_eq("cfg_ready", cfg_ready, !m_pending);
        check_eq("cfg_err", cfg_err, m_err);
    endtask

    // One clock: advance the model by the rules using pre-edge inputs, then compare.
    task automatic step();
        bit was_stb, was_fe, ok;
        @(posedge clk_x5);
        if (resetn) begin
            was_stb = (m_k > 0) && (m_k % DIV == 0);
            was_fe  = was_stb && (m_fp == m_t[0] * m_t[4] - 1);
            m_err   = 1'b0;
            if (was_stb) m_fp = was_fe ? 0 : m_fp + 1;
            if (was_fe && m_pending) begin
                m_t       = m_sh;
                m_pending = 1'b0;
            end else if (cfg_valid && !m_pending) begin
`ifdef TIMING_CHECK_EN
                ok = cfg_legal(cfg_data);
`else
                ok = 1'b1;
`endif
                if (ok) begin
                    for (int i = 0; i < 8; i++) m_sh[i] = int'(cfg_data[i*CW +: CW]);
                    m_pending = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            m_k++;
        end
        #1;
        check_outputs();
    endtask

    task automatic wait_fe(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!frame_end && n < budget);
        if (!frame_end) check_eq("frame_end_timeout", frame_end, 1);
    endtask

    // Call while sitting in a frame_end cycle; runs exactly one frame.
    task automatic measure_frame(output int strobes, output int des, output int hs_cnt,
                                 output int vs_cnt, output int xmax, output int ymax);
        int n = 0;
        strobes = 0; des = 0; hs_cnt = 0; vs_cnt = 0; xmax = 0; ymax = 0;
        do begin
            step();
            n++;
            if (pix_stb) begin
                strobes++;
                if (de) des++;
                if (hsync) hs_cnt++;
                if (vsync) vs_cnt++;
                if (int'(x) > xmax) xmax = int'(x);
                if (int'(y) > ymax) ymax = int'(y);
            end
        end while (!frame_end && n < 8000);
        if (!frame_end) check_eq("measure_timeout", frame_end, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, cnt, st, ds, hc_n, vc_n, xm, ym, nfe, nb;
        logic [8*CW-1:0] c;

        model_reset();
        repeat (3) step();
        @(negedge clk_x5);
        resetn = 1'b1;

        first = 0;
        for (int i = 0; i < 20 && first == 0; i++) begin
            step();
            if (pix_stb) first = m_k;
        end
        check_eq("first_stb_cycle", first, DIV);
        cnt = 0;
        repeat (10 * DIV) begin
            step();
            if (pix_stb) cnt++;
        end
        check_eq("stb_duty", cnt, 10);

        // Full frame with power-on timing.
        wait_fe(2 * P_HT * P_VT * DIV + 100);
        measure_frame(st, ds, hc_n, vc_n, xm, ym);
        check_eq("frame_strobes", st, P_HT * P_VT);
        check_eq("frame_de", ds, (P_HA1 - P_HA0) * (P_VA1 - P_VA0));
        check_eq("frame_hsync", hc_n, P_HS * P_VT);
        check_eq("frame_vsync", vc_n, P_VS * P_HT);
        check_eq("x_max", xm, P_HA1 - P_HA0 - 1);
        check_eq("y_max", ym, P_VA1 - P_VA0 - 1);

        // 8x8 timing offered mid-frame.
        repeat (200) step();
        cfg_valid = 1'b1;
        cfg_data  = pack_cfg(8, 1, 2, 6, 8, 1, 2, 6);
        step();
        cfg_valid = 1'b0;
        check_eq("ready_after_xfer", cfg_ready, 0);
        wait_fe(2 * P_HT * P_VT * DIV);
        check_eq("ready_at_fe", cfg_ready, 0);
        measure_frame(st, ds, hc_n, vc_n, xm, ym);
        check_eq("frame8_strobes", st, 64);
        check_eq("frame8_de", ds, 16);

        // Offer in the frame_end cycle: one more old frame first.
        cfg_valid = 1'b1;
        cfg_data  = pack_cfg(10, 2, 3, 9, 6, 1, 2, 5);
        step();
        cfg_valid = 1'b0;
        check_eq("ready_fe_offer", cfg_ready, 0);
        measure_frame(st, ds, hc_n, vc_n, xm, ym);
        check_eq("old_frame_kept", st, 64);
        measure_frame(st, ds, hc_n, vc_n, xm, ym);
        check_eq("new_frame_strobes", st, 60);
        check_eq("new_frame_de", ds, 18);

        // Random timings at random offsets, with ignored offers while pending.
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(300, 0)) step();
            c = rand_legal_cfg();
`ifdef TIMING_CHECK_EN
            if ($urandom_range(3, 0) == 0) c[3*CW +: CW] = c[0 +: CW] + CW'(1);
`endif
            cfg_valid = 1'b1;
            cfg_data  = c;
            step();
            nfe = 0;
            nb  = 0;
            while (nfe < 2 && nb < 4000) begin
                cfg_valid = m_pending && ($urandom_range(3, 0) == 0);
                cfg_data  = {$urandom, $urandom, $urandom};
                step();
                nb++;
                if (frame_end) nfe++;
            end
            cfg_valid = 1'b0;
            if (nfe < 2) check_eq("rand_frame_timeout", frame_end, 1);
        end

`ifdef TIMING_CHECK_EN
        // H_ACT1 beyond H_TOTAL must be rejected.
        repeat (7) step();
        cfg_valid = 1'b1;
        cfg_data  = pack_cfg(800, 96, 144, 900, 525, 2, 35, 515);
        step();
        cfg_valid = 1'b0;
        check_eq("bad_cfg_err", cfg_err, 1);
        check_eq("bad_cfg_ready", cfg_ready, 1);
        step();
        check_eq("bad_cfg_err_pulse", cfg_err, 0);
        cnt = m_t[0] * m_t[4];
        wait_fe(4000);
        measure_frame(st, ds, hc_n, vc_n, xm, ym);
        check_eq("bad_cfg_timing_kept", st, cnt);
`endif

        // Reset mid-line with a pending config.
        repeat (13) step();
        cfg_valid = 1'b1;
        cfg_data  = pack_cfg(8, 1, 2, 6, 8, 1, 2, 6);
        step();
        cfg_valid = 1'b0;
        repeat (7) step();
        check_eq("pending_before_reset", cfg_ready, 0);
        @(negedge clk_x5);
        resetn = 1'b0;
        model_reset();
        #1;
        check_outputs();
        repeat (2) step();
        @(negedge clk_x5);
        resetn = 1'b1;
        wait_fe(2 * P_HT * P_VT * DIV + 100);
        measure_frame(st, ds, hc_n, vc_n, xm, ym);
        check_eq("post_reset_strobes", st, P_HT * P_VT);
        check_eq("post_reset_de", ds, (P_HA1 - P_HA0) * (P_VA1 - P_VA0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
